// File: rtl/umi_mem_initiator.sv
// Single-outstanding UMI host: turns local read/write commands into one-word UMI
// requests, waits for the matching response (or watchdog expiry) and reports back.
module umi_mem_initiator #(
    parameter int          DW      = 32,
    parameter int          AW      = 64,
    parameter int          CW      = 32,
    parameter logic [AW-1:0] SRCADDR = '0,
    parameter int          TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          nreset,
    // local command port
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic          cmd_posted,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_error,
    output logic          rsp_timeout,
    // UMI request channel
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    // UMI response channel
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    localparam logic [2:0]  SIZE   = 3'($clog2(DW / 8));
    localparam bit          TMO_EN = (TIMEOUT != 0);
    localparam logic [31:0] TLIM   = (TIMEOUT > 1) ? 32'(TIMEOUT - 1) : 32'd0;

    localparam logic [4:0] OP_READ      = 5'h01;
    localparam logic [4:0] OP_RESP_READ = 5'h02;
    localparam logic [4:0] OP_WRITE     = 5'h03;
    localparam logic [4:0] OP_RESP_WR   = 5'h04;
    localparam logic [4:0] OP_POSTED    = 5'h05;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic          posted_q, posted_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic [31:0]   timer_q, timer_d;

    logic [4:0]    req_op;
    logic [4:0]    exp_rsp_op;
    logic [CW-1:0] cmd_word;
    logic          req_active;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            posted_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            posted_q <= posted_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            timer_q  <= timer_d;
        end
    end

    assign req_op     = (write_q && posted_q) ? OP_POSTED : (write_q ? OP_WRITE : OP_READ);
    assign exp_rsp_op = write_q ? OP_RESP_WR : OP_RESP_READ;

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        posted_d = posted_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d  = cmd_write;
                    posted_d = cmd_posted;
                    addr_d   = cmd_addr;
                    wdata_d  = cmd_wdata;
                    err_d    = 1'b0;
                    tmo_d    = 1'b0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (uhost_req_ready) begin
                    timer_d = '0;
                    state_d = (write_q && posted_q) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (TMO_EN) begin
                    timer_d = timer_q + 32'd1;
                end
                // A response in the expiry cycle takes priority over the watchdog.
                if (uhost_resp_valid) begin
                    if (!write_q) begin
                        rdata_d = uhost_resp_data;
                    end
                    err_d   = (uhost_resp_cmd[4:0] != exp_rsp_op) || (uhost_resp_cmd[26:24] != 3'b000);
                    state_d = DONE;
                end else if (TMO_EN && ((timer_q + 32'd1) >= TLIM)) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_word       = '0;
        cmd_word[4:0]  = req_op;
        cmd_word[7:5]  = SIZE;
        cmd_word[22]   = 1'b1;
    end

    // Request fields are forced to zero outside REQ so every output reads 0 in reset.
    assign req_active        = (state_q == REQ);
    assign uhost_req_valid   = req_active;
    assign uhost_req_cmd     = req_active ? cmd_word : '0;
    assign uhost_req_dstaddr = req_active ? addr_q : '0;
    assign uhost_req_srcaddr = req_active ? SRCADDR : '0;
    assign uhost_req_data    = (req_active && write_q) ? wdata_q : '0;
    assign uhost_resp_ready  = (state_q == WAIT);

    assign cmd_ready   = nreset && (state_q == IDLE);
    assign rsp_valid   = (state_q == DONE);
    assign rsp_error   = (state_q == DONE) && err_q;
    assign rsp_timeout = (state_q == DONE) && tmo_q;
    assign rsp_rdata   = rdata_q;

    logic unused_inputs;
    assign unused_inputs = ^{uhost_resp_dstaddr, uhost_resp_srcaddr,
                             uhost_resp_cmd[CW-1:27], uhost_resp_cmd[23:5]};

endmodule
